codec_cfg_sched: RTL and testbench

Register-write scheduler for the WM8731 audio codec control port. After reset it runs the fixed codec initialisation sequence, then forwards volume updates from the volume controller (`Go` pulse plus an 8-bit `volume` code) as headphone-volume register writes. It sits between the volume controller and the I2C byte-level master, and it is the only block that issues I2C transactions.

---
 rtl/codec_cfg_sched.sv | 159 +++++++++++++++
 tb/tb_codec_cfg_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_sched.sv
// WM8731 control-port write scheduler: power-up wait, fixed init table, then
// headphone-volume writes on request. Frames are loaded and started on the edge entering an ISSUE state.
module codec_cfg_sched #(
    parameter logic [7:0] DEV_ADDR  = 8'h34,
    parameter int         PWR_DLY   = 16,
    parameter int         MAX_RETRY = 3
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Go,
    input  logic [7:0]  volume,
    output logic        i2c_start,
    output logic [23:0] i2c_wdata,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        init_done,
    output logic        busy,
    output logic        cfg_err
);

    localparam int CNT_W = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWR_DLY - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_ISSUE, INIT_WAIT, IDLE, VOL_ISSUE, VOL_WAIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         idx;
    logic [RTY_W-1:0]   retry;
    logic [7:0]         cur_vol;
    logic               vol_pend;
    logic [23:0]        vol_frame;
    logic               nack_retry;
    logic               nack_final;

    // {reg[6:0], data[8:0]} for each init step; entry 3 tracks the live volume
    function automatic logic [15:0] init_entry(input logic [3:0] i, input logic [7:0] vol);
        case (i)
            4'd0:    return {7'd15, 9'h000};
            4'd1:    return {7'd0,  9'h017};
            4'd2:    return {7'd1,  9'h017};
            4'd3:    return {7'd2,  1'b1, vol};
            4'd4:    return {7'd4,  9'h012};
            4'd5:    return {7'd5,  9'h000};
            4'd6:    return {7'd6,  9'h000};
            4'd7:    return {7'd7,  9'h002};
            4'd8:    return {7'd8,  9'h000};
            default: return {7'd9,  9'h001};
        endcase
    endfunction

    assign vol_frame  = {DEV_ADDR, 7'd2, 1'b1, cur_vol};
    assign nack_retry = i2c_nack && (retry < RTY_MAX);
    assign nack_final = i2c_nack && (retry == RTY_MAX);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            idx       <= '0;
            retry     <= '0;
            cur_vol   <= 8'hC3;
            vol_pend  <= 1'b0;
            i2c_start <= 1'b0;
            i2c_wdata <= '0;
            init_done <= 1'b0;
            busy      <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            i2c_start <= 1'b0;
            busy      <= 1'b1;
            case (state)
                PWR_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state     <= INIT_ISSUE;
                        i2c_wdata <= {DEV_ADDR, init_entry(idx, cur_vol)};
                        i2c_start <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_ISSUE: state <= INIT_WAIT;
                INIT_WAIT: begin
                    if (i2c_done) begin
                        if (nack_retry) begin
                            // frame register is left untouched, so the retry resends it verbatim
                            retry     <= retry + 1'b1;
                            state     <= INIT_ISSUE;
                            i2c_start <= 1'b1;
                        end else begin
                            retry <= '0;
                            if (nack_final) cfg_err <= 1'b1;
                            if (idx == 4'd9) begin
                                init_done <= 1'b1;
                                if (vol_pend) begin
                                    state     <= VOL_ISSUE;
                                    i2c_wdata <= vol_frame;
                                    i2c_start <= 1'b1;
                                    vol_pend  <= 1'b0;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                idx       <= idx + 4'd1;
                                state     <= INIT_ISSUE;
                                i2c_wdata <= {DEV_ADDR, init_entry(idx + 4'd1, cur_vol)};
                                i2c_start <= 1'b1;
                            end
                        end
                    end
                end
                IDLE: begin
                    if (vol_pend) begin
                        state     <= VOL_ISSUE;
                        i2c_wdata <= vol_frame;
                        i2c_start <= 1'b1;
                        vol_pend  <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                VOL_ISSUE: state <= VOL_WAIT;
                VOL_WAIT: begin
                    if (i2c_done) begin
                        if (nack_retry) begin
                            retry     <= retry + 1'b1;
                            state     <= VOL_ISSUE;
                            i2c_start <= 1'b1;
                        end else begin
                            retry <= '0;
                            if (nack_final) cfg_err <= 1'b1;
                            if (vol_pend) begin
                                state     <= VOL_ISSUE;
                                i2c_wdata <= vol_frame;
                                i2c_start <= 1'b1;
                                vol_pend  <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= PWR_WAIT;
            endcase
            // last assignment wins, so a request racing the issue edge stays pending
            if (Go) begin
                cur_vol  <= volume;
                vol_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_codec_cfg_sched.sv
// Bench for codec_cfg_sched: transaction-level reference model compared every cycle,
// directed scenarios with literal frame expectations, then a randomized phase.
module tb_codec_cfg_sched;

    localparam int PWR_DLY   = 16;
    localparam int MAX_RETRY = 3;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Go = 1'b0;
    logic [7:0]  volume = 8'h00;
    logic        i2c_start;
    logic [23:0] i2c_wdata;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        init_done;
    logic        busy;
    logic        cfg_err;

    codec_cfg_sched #(.DEV_ADDR(8'h34), .PWR_DLY(PWR_DLY), .MAX_RETRY(MAX_RETRY)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Go(Go), .volume(volume),
        .i2c_start(i2c_start), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .init_done(init_done), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected init frames with the reset volume 0xC3 in entry 3
    logic [23:0] init_tbl [10] = '{24'h341E00, 24'h340017, 24'h340217, 24'h3405C3, 24'h340812,
                                   24'h340A00, 24'h340C00, 24'h340E02, 24'h341000, 24'h341201};

    function automatic logic [23:0] init_frame(input int i, input logic [7:0] v);
        logic [23:0] f;
        f = init_tbl[i];
        if (i == 3) f = {16'h3405, v};
        return f;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    bit          m_started = 0, m_inflight = 0, m_init = 0, m_err = 0, m_pend = 0, m_start = 0;
    int          m_ticks = 0, m_idx = 0, m_retry = 0, m_age = 0;
    logic [7:0]  m_vol = 8'hC3;
    logic [23:0] m_frame = 24'h0;

    always @(posedge Clk) begin
        if (!Rst_n) begin
            m_started = 0; m_inflight = 0; m_init = 0; m_err = 0; m_pend = 0; m_start = 0;
            m_ticks = 0; m_idx = 0; m_retry = 0; m_age = 0; m_vol = 8'hC3; m_frame = 24'h0;
        end else begin
            m_start = 0;
            if (!m_started) begin
                if (m_ticks == PWR_DLY - 1) begin
                    m_started = 1; m_inflight = 1; m_age = 0;
                    m_frame = init_frame(0, m_vol); m_start = 1;
                end else m_ticks++;
            end else if (m_inflight) begin
                // a response only counts once the write has been out for a full cycle
                if (m_age >= 1 && i2c_done) begin
                    if (i2c_nack && m_retry < MAX_RETRY) begin
                        m_retry++; m_start = 1; m_age = 0;
                    end else begin
                        if (i2c_nack) m_err = 1;
                        m_retry = 0;
                        if (!m_init && m_idx < 9) begin
                            m_idx++; m_frame = init_frame(m_idx, m_vol); m_start = 1; m_age = 0;
                        end else begin
                            m_init = 1;
                            if (m_pend) begin
                                m_frame = {16'h3405, m_vol}; m_start = 1; m_age = 0; m_pend = 0;
                            end else m_inflight = 0;
                        end
                    end
                end else m_age++;
            end else if (m_pend) begin
                m_frame = {16'h3405, m_vol}; m_start = 1; m_age = 0; m_pend = 0; m_inflight = 1;
            end
            if (Go) begin
                m_vol = volume; m_pend = 1;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge Clk) begin
        if (chk_en) begin
            check("cyc_start", i2c_start, m_start);
            check("cyc_wdata", i2c_wdata, m_frame);
            check("cyc_busy", busy, !m_init || m_inflight);
            check("cyc_init_done", init_done, m_init);
            check("cyc_cfg_err", cfg_err, m_err);
        end
    end

    // ---------------- frame log and cycle counter ----------------
    int          cyc = 0;
    logic [23:0] frames [$];
    int          start_cyc [$];

    always @(posedge Clk) begin
        if (!Rst_n) cyc = 0;
        else cyc++;
    end

    always @(negedge Clk) begin
        if (i2c_start) begin
            frames.push_back(i2c_wdata);
            start_cyc.push_back(cyc);
        end
    end

    // ---------------- I2C responder ----------------
    int resp_dly = 1;
    bit rand_resp = 0;
    bit nack4_on = 0;
    int nack_pct = 0;
    bit spur_req = 0;

    initial begin
        int dcnt;
        int r4_run;
        dcnt = 0;
        r4_run = 0;
        forever begin
            @(negedge Clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (spur_req) begin
                i2c_done = 1'b1;
            end else if (i2c_start) begin
                dcnt = rand_resp ? int'($urandom_range(1, 4)) : resp_dly;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    i2c_done = 1'b1;
                    if (nack4_on && i2c_wdata[15:9] == 7'd4 && r4_run < 4) begin
                        i2c_nack = 1'b1;
                        r4_run++;
                    end else begin
                        if (i2c_wdata[15:9] != 7'd4) r4_run = 0;
                        if (nack_pct > 0 && int'($urandom_range(0, 99)) < nack_pct) i2c_nack = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_init(input int bound);
        int n;
        n = 0;
        while (!init_done && n < bound) begin
            tick();
            n++;
        end
        check("init_timeout", init_done, 1);
    endtask

    task automatic wait_start(input int bound);
        int n;
        n = 0;
        tick();
        while (!i2c_start && n < bound) begin
            tick();
            n++;
        end
        check("start_timeout", i2c_start, 1);
    endtask

    task automatic go(input logic [7:0] v, output int edge_n);
        Go = 1'b1;
        volume = v;
        tick();
        Go = 1'b0;
        edge_n = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, i2c_start, 0);
        check({tag, "_wdata"}, i2c_wdata, 0);
        check({tag, "_init_done"}, init_done, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    initial begin
        int base, n0, go_edge, r4;

        Rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        chk_en = 1;

        // ---- boot sequence, 1-cycle responder ----
        base = frames.size();
        Rst_n = 1'b1;
        wait_init(400);
        check("init_nframes", frames.size() - base, 10);
        if (frames.size() - base == 10) begin
            for (int i = 0; i < 10; i++) check($sformatf("init_frame%0d", i), frames[base + i], init_tbl[i]);
            check("first_frame", frames[base], 24'h341E00);
            check("fourth_frame", frames[base + 3], 24'h3405C3);
            // start visible in the cycle ending at edge PWR_DLY+1
            check("first_start_cyc", start_cyc[base], PWR_DLY);
        end
        check("boot_init_done", init_done, 1);
        check("boot_busy", busy, 0);

        // ---- single volume write from IDLE ----
        n0 = frames.size();
        go(8'hB2, go_edge);
        wait_start(10);
        check("vol_start_lat", cyc - go_edge, 1);
        check("vol_frame", i2c_wdata, 24'h3405B2);
        check("vol_busy_start", busy, 1);
        tick();
        check("vol_busy_wait", busy, 1);
        tick();
        check("vol_busy_after", busy, 0);
        check("vol_nframes", frames.size() - n0, 1);

        // ---- two requests during one VOL_WAIT collapse to the latest ----
        resp_dly = 8;
        go(8'hC0, go_edge);
        wait_start(10);
        n0 = frames.size();
        go(8'hB6, go_edge);
        go(8'hBB, go_edge);
        repeat (30) tick();
        check("coalesce_nframes", frames.size() - n0, 1);
        if (frames.size() > 0) check("coalesce_frame", frames[frames.size() - 1], 24'h3405BB);
        resp_dly = 1;

        // ---- spurious done in IDLE ----
        n0 = frames.size();
        spur_req = 1;
        tick();
        spur_req = 0;
        repeat (5) tick();
        check("spur_nframes", frames.size() - n0, 0);
        check("spur_busy", busy, 0);
        check("spur_init_done", init_done, 1);

        // ---- entry 4 NACKed until retries run out ----
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        nack4_on = 1;
        base = frames.size();
        wait_init(500);
        nack4_on = 0;
        r4 = 0;
        for (int i = base; i < frames.size(); i++) if (frames[i][15:9] == 7'd4) r4++;
        check("nack_r4_frames", r4, MAX_RETRY + 1);
        check("nack_cfg_err", cfg_err, 1);
        check("nack_init_done", init_done, 1);
        check("nack_nframes", frames.size() - base, 13);
        if (frames.size() - base == 13) check("nack_entry5", frames[base + 8], 24'h340A00);

        // ---- reset in the middle of a volume write ----
        resp_dly = 8;
        go(8'hA0, go_edge);
        wait_start(10);
        tick();
        tick();
        Rst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        base = frames.size();
        Rst_n = 1'b1;
        resp_dly = 1;
        wait_init(400);
        check("midrst_nframes", frames.size() - base, 10);
        if (frames.size() - base == 10) begin
            check("midrst_first_cyc", start_cyc[base], PWR_DLY);
            check("midrst_entry3", frames[base + 3], 24'h3405C3);
        end

        // ---- randomized traffic ----
        rand_resp = 1;
        nack_pct = 20;
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            Rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 11) == 0) begin
                Go = 1'b1;
                volume = 8'($urandom);
            end else begin
                Go = 1'b0;
            end
            tick();
        end
        Go = 1'b0;
        Rst_n = 1'b1;
        repeat (20) tick();
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
